osc_voice_mixer: RTL and testbench
==================================

Name: osc_voice_mixer

Overview:
- Consumes the time-multiplexed 17-bit signed sine samples from the oscillator stage, one per (voice, oscillator) slot.
- Scales each sample by a per-oscillator 8-bit level and mutes free voices.
- Sums the V_OSC oscillators of each voice into one per-voice sample, emitted with a one-cycle valid strobe and voice index.
- Sits between the oscillator sine lookup and the per-voice envelope/VCA stage.

Parameters:
- VOICES, 8, number of voices.
- V_OSC, 4, oscillators per voice; power of two, at least 1.
- V_WIDTH, 3, log2(VOICES).
- O_WIDTH, 2, log2(V_OSC).

Ports:
- sCLK_XVXOSC  in  1  oscillator-rate clock, all logic on posedge.
- reset_reg  in  1  synchronous active-high reset.
- sine_in  in  17 signed  oscillator sample.
- sine_valid  in  1  sine_in, sine_vx and sine_ox valid this cycle.
- sine_vx  in  V_WIDTH  voice index of sine_in.
- sine_ox  in  O_WIDTH  oscillator index of sine_in.
- osc_level  in  V_OSC*8  packed unsigned levels; level[o] = osc_level[o*8+7:o*8].
- voice_free  in  VOICES  1 = voice idle; its samples are forced to 0.
- err_clr  in  1  clears seq_err.
- voice_out  out  17+O_WIDTH signed  summed voice sample.
- voice_out_vx  out  V_WIDTH  voice index of voice_out.
- voice_out_valid  out  1  single-cycle strobe.
- seq_err  out  1  sticky slot-ordering error flag.

Behaviour:
- Reset values: voice_out=0, voice_out_vx=0, voice_out_valid=0, seq_err=0, FSM=IDLE, accumulator=0, all stage-1 registers cleared.
- Reset asserted mid-group discards the partial sum. No valid is emitted for that group.
- Stage 1 captures on every posedge where sine_valid=1:
  - prod = (sine_in * {1'b0, level[sine_ox]}) >>> 8, keeping bits [24:8] of the 26-bit signed product as 17-bit signed. Shift is arithmetic (floor).
  - prod is forced to 0 when voice_free[sine_vx]=1.
  - vx, ox and valid tags are registered alongside prod. The stage-1 valid is 0 when sine_valid=0.
- Stage 2 is the FSM, acting on stage-1 outputs. States are IDLE and ACCUM, plus a registered exp_ox and cur_vx.
- IDLE, s1 valid, ox==0:
  - acc = sign-extended prod, cur_vx = vx, exp_ox = 1.
  - If V_OSC==1, emit immediately and stay in IDLE; otherwise go to ACCUM.
- IDLE, s1 valid, ox!=0: set seq_err, discard the sample, stay in IDLE.
- ACCUM, s1 valid, ox==exp_ox and vx==cur_vx:
  - acc = acc + prod, exp_ox = exp_ox + 1.
  - If ox==V_OSC-1, emit and go to IDLE.
- ACCUM, s1 valid, mismatch: set seq_err and drop the partial sum.
  - If ox==0, restart the group with this sample (same as IDLE, ox==0).
  - Otherwise go to IDLE.
- ACCUM with no s1 valid holds state. Gaps within a group are legal.
- Emit: on the same posedge, register voice_out = final sum (acc + prod), voice_out_vx = cur_vx, and voice_out_valid = 1 for exactly one cycle.
  - voice_out holds its value until the next emit.
- Latency: last slot (ox=V_OSC-1) presented in cycle t gives voice_out_valid high in cycle t+2. Back-to-back groups at one slot per cycle are sustained with no bubbles.
- Width: the sum of V_OSC 17-bit values fits in 17+O_WIDTH bits, so no overflow is possible and the sum is not wrapped.
- seq_err: err_clr clears it. If err_clr and a new error occur in the same cycle, set wins.
- Level and voice_free are sampled at stage 1 only. Changing them mid-group affects only later slots.

Optional Feature:
- OSC_VOICE_MIXER_SAT_EN defined: voice_out is still 17+O_WIDTH wide, but its value is saturated to the signed 17-bit range [-65536, 65535], sign-extended. The clip is applied in the emit register; latency is unchanged.
- Not defined: the full-precision sum is output.

Test Plan:
- Single voice, vx=3, all levels 0xFF, free=0, samples 1000/2000/-500/100 in ox order 0..3, back-to-back → one strobe 2 cycles after ox=3; voice_out = 996+1992+(-499)+99 = 2588; vx=3; seq_err=0.
- Level scaling: sine_in=-1, level=0x01 → prod=-1 (floor). Sine 0x7FFF with level 0x80 → 16383. All four oscillators at 0x80 with 0x7FFF → voice_out=65532.
- Max sum: four samples of 65535 at level 0xFF → 65279*4 = 261116 without macro; 65535 with OSC_VOICE_MIXER_SAT_EN.
- Muting: voice_free[5]=1, group for vx=5 with nonzero samples → strobe with voice_out=0. Next group vx=6 (free=0) sums normally with no bubble, strobe 2 cycles after its ox=3.
- Ordering: ox sequence 0,1,3 → seq_err=1 and no strobe; then a clean 0..3 group → correct strobe. err_clr pulse → seq_err=0. vx change mid-group → seq_err=1, and a new group restarted at ox=0 emits correctly.
- Reset between ox=1 and ox=2, then slots 2,3 → no strobe, seq_err stays 0 until the next out-of-order slot arrives (ox=2 arriving in IDLE sets it). Gap of 5 idle cycles inside a valid group → correct sum.

Source files
------------

// File: rtl/osc_voice_mixer.sv
// Level-scales time-multiplexed oscillator samples and sums the V_OSC oscillators of each voice.
// Optional: define OSC_VOICE_MIXER_SAT_EN to clip voice_out to the signed 17-bit range.
module osc_voice_mixer #(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2
) (
    input  logic                       sCLK_XVXOSC,
    input  logic                       reset_reg,
    input  logic signed [16:0]         sine_in,
    input  logic                       sine_valid,
    input  logic [V_WIDTH-1:0]         sine_vx,
    input  logic [O_WIDTH-1:0]         sine_ox,
    input  logic [V_OSC*8-1:0]         osc_level,
    input  logic [VOICES-1:0]          voice_free,
    input  logic                       err_clr,
    output logic signed [16+O_WIDTH:0] voice_out,
    output logic [V_WIDTH-1:0]         voice_out_vx,
    output logic                       voice_out_valid,
    output logic                       seq_err
);
    localparam int SW = 17 + O_WIDTH;

    typedef enum logic {IDLE, ACCUM} state_t;

    logic [7:0]          level_sel;
    logic signed [25:0]  full_prod;
    logic signed [16:0]  prod_d, s1_prod_q;
    logic                s1_valid_q;
    logic [V_WIDTH-1:0]  s1_vx_q;
    logic [O_WIDTH-1:0]  s1_ox_q;

    state_t              state_q, state_d;
    logic signed [SW-1:0] acc_q, acc_d, prod_ext, sum, emit_val;
    logic [O_WIDTH-1:0]  exp_ox_q, exp_ox_d;
    logic [V_WIDTH-1:0]  cur_vx_q, cur_vx_d, emit_vx;
    logic                emit, err_set, start, match;

    logic signed [SW-1:0] voice_out_q, voice_out_d;
    logic [V_WIDTH-1:0]  voice_out_vx_q, voice_out_vx_d;
    logic                valid_q, seq_err_q, seq_err_d;

    function automatic logic signed [SW-1:0] clip(input logic signed [SW-1:0] v);
`ifdef OSC_VOICE_MIXER_SAT_EN
        logic signed [SW-1:0] max_v, min_v;
        max_v = 65535;
        min_v = -65536;
        if (v > max_v) return max_v;
        if (v < min_v) return min_v;
        return v;
`else
        return v;
`endif
    endfunction

    // Stage 1: the level is treated as unsigned, so a zero MSB is prepended before the signed multiply.
    always_comb begin
        level_sel = osc_level[{sine_ox, 3'b000} +: 8];
        full_prod = sine_in * $signed({1'b0, level_sel});
        prod_d    = voice_free[sine_vx] ? 17'sd0 : 17'(full_prod >>> 8);
    end

    always_ff @(posedge sCLK_XVXOSC) begin
        if (reset_reg) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_vx_q    <= '0;
            s1_ox_q    <= '0;
        end else begin
            s1_valid_q <= sine_valid;
            if (sine_valid) begin
                s1_prod_q <= prod_d;
                s1_vx_q   <= sine_vx;
                s1_ox_q   <= sine_ox;
            end
        end
    end

    always_comb begin
        prod_ext = SW'(s1_prod_q);
        sum      = acc_q + prod_ext;
        match    = (s1_ox_q == exp_ox_q) && (s1_vx_q == cur_vx_q);
        state_d  = state_q;
        acc_d    = acc_q;
        exp_ox_d = exp_ox_q;
        cur_vx_d = cur_vx_q;
        emit     = 1'b0;
        emit_val = sum;
        emit_vx  = cur_vx_q;
        err_set  = 1'b0;
        start    = 1'b0;
        if (s1_valid_q) begin
            case (state_q)
                IDLE: begin
                    if (s1_ox_q == '0) start = 1'b1;
                    else               err_set = 1'b1;
                end
                ACCUM: begin
                    if (match) begin
                        acc_d    = sum;
                        exp_ox_d = exp_ox_q + 1'b1;
                        if (s1_ox_q == O_WIDTH'(V_OSC - 1)) begin
                            emit    = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        err_set = 1'b1;
                        acc_d   = '0;
                        state_d = IDLE;
                        if (s1_ox_q == '0) start = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // A slot at ox 0 opens a new group, whether from IDLE or after an ordering fault.
            if (start) begin
                acc_d    = prod_ext;
                cur_vx_d = s1_vx_q;
                exp_ox_d = O_WIDTH'(1);
                if (V_OSC == 1) begin
                    emit     = 1'b1;
                    emit_val = prod_ext;
                    emit_vx  = s1_vx_q;
                    state_d  = IDLE;
                end else begin
                    state_d  = ACCUM;
                end
            end
        end
        voice_out_d    = emit ? clip(emit_val) : voice_out_q;
        voice_out_vx_d = emit ? emit_vx : voice_out_vx_q;
        seq_err_d      = err_set | (seq_err_q & ~err_clr);
    end

    always_ff @(posedge sCLK_XVXOSC) begin
        if (reset_reg) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            exp_ox_q       <= '0;
            cur_vx_q       <= '0;
            voice_out_q    <= '0;
            voice_out_vx_q <= '0;
            valid_q        <= 1'b0;
            seq_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            exp_ox_q       <= exp_ox_d;
            cur_vx_q       <= cur_vx_d;
            voice_out_q    <= voice_out_d;
            voice_out_vx_q <= voice_out_vx_d;
            valid_q        <= emit;
            seq_err_q      <= seq_err_d;
        end
    end

    assign voice_out       = voice_out_q;
    assign voice_out_vx    = voice_out_vx_q;
    assign voice_out_valid = valid_q;
    assign seq_err         = seq_err_q;

endmodule

// File: tb/tb_osc_voice_mixer.sv
// Self-checking bench for osc_voice_mixer: directed spec scenarios plus randomized groups
// checked against an arithmetic reference model (floor-scaled products, per-voice sums).
module tb_osc_voice_mixer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_reg = 1'b1;
    logic signed [16:0] sine_in = '0;
    logic               sine_valid = 1'b0;
    logic [2:0]         sine_vx = '0;
    logic [1:0]         sine_ox = '0;
    logic [31:0]        osc_level = '0;
    logic [7:0]         voice_free = '0;
    logic               err_clr = 1'b0;
    logic signed [18:0] voice_out;
    logic [2:0]         voice_out_vx;
    logic               voice_out_valid;
    logic               seq_err;

    osc_voice_mixer dut (
        .sCLK_XVXOSC(clk), .reset_reg(reset_reg), .sine_in(sine_in), .sine_valid(sine_valid),
        .sine_vx(sine_vx), .sine_ox(sine_ox), .osc_level(osc_level), .voice_free(voice_free),
        .err_clr(err_clr), .voice_out(voice_out), .voice_out_vx(voice_out_vx),
        .voice_out_valid(voice_out_valid), .seq_err(seq_err)
    );

`ifdef OSC_VOICE_MIXER_SAT_EN
    localparam int MAX_POS = 65535;
    localparam int MAX_NEG = -65536;
`else
    localparam int MAX_POS = 261116;
    localparam int MAX_NEG = -261120;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0, total_cnt = 0;
    int mon_val[$], mon_vx[$], mon_cyc[$];
    int exp_val[$], exp_vx[$], exp_cyc[$];
    int slot_sum, last_cyc;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (voice_out_valid) begin
            mon_val.push_back(int'(voice_out));
            mon_vx.push_back(int'(voice_out_vx));
            mon_cyc.push_back(cyc);
        end
    end

    function automatic int model_prod(input int s, input int lvl, input bit muted);
        int p, q;
        p = s * lvl;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return muted ? 0 : q;
    endfunction

    function automatic int model_out(input int s);
`ifdef OSC_VOICE_MIXER_SAT_EN
        if (s > 65535) return 65535;
        if (s < -65536) return -65536;
`endif
        return s;
    endfunction

    task automatic clear_queues();
        mon_val.delete(); mon_vx.delete(); mon_cyc.delete();
        exp_val.delete(); exp_vx.delete(); exp_cyc.delete();
    endtask

    task automatic send_slot(input int vx, input int ox, input int s, input bit rnd);
        @(posedge clk); #1;
        if (rnd) begin
            osc_level  = $urandom;
            voice_free = 8'($urandom & $urandom & $urandom);
        end
        sine_valid = 1'b1;
        sine_vx    = 3'(vx);
        sine_ox    = 2'(ox);
        sine_in    = 17'(s);
        slot_sum   = slot_sum + model_prod(s, int'(osc_level[ox*8 +: 8]), voice_free[vx]);
        last_cyc   = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sine_valid = 1'b0;
            sine_in    = 17'($urandom);
            sine_ox    = 2'($urandom);
        end
    endtask

    task automatic send_group(input int vx, input int a, input int b, input int c, input int d,
                              input int gap, input bit rnd);
        slot_sum = 0;
        send_slot(vx, 0, a, rnd);
        send_slot(vx, 1, b, rnd);
        if (gap > 0) idle(gap);
        send_slot(vx, 2, c, rnd);
        send_slot(vx, 3, d, rnd);
        exp_val.push_back(model_out(slot_sum));
        exp_vx.push_back(vx);
        exp_cyc.push_back(last_cyc + 2);
    endtask

    task automatic pulse_err_clr();
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_reg = 1'b1; sine_valid = 1'b1; sine_in = 17'sd1234; osc_level = '1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (voice_out !== 19'sd0) $display("[TB] FAIL reset_out: got %0d expected 0", voice_out); else pass_cnt++;
        total_cnt++; if (voice_out_vx !== 3'd0) $display("[TB] FAIL reset_vx: got %0d expected 0", voice_out_vx); else pass_cnt++;
        total_cnt++; if (voice_out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", voice_out_valid); else pass_cnt++;
        total_cnt++; if (seq_err !== 1'b0) $display("[TB] FAIL reset_err: got %0b expected 0", seq_err); else pass_cnt++;
        sine_valid = 1'b0;
        reset_reg  = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        clear_queues();
        osc_level = 32'hFFFF_FFFF; voice_free = '0;
        send_group(3, 1000, 2000, -500, 100, 0, 0);
        idle(3);
        total_cnt++; if (mon_val.size() !== 1) $display("[TB] FAIL basic_count: got %0d expected 1", mon_val.size()); else pass_cnt++;
        if (mon_val.size() >= 1) begin
            total_cnt++; if (mon_val[0] !== 2588) $display("[TB] FAIL basic_val: got %0d expected 2588", mon_val[0]); else pass_cnt++;
            total_cnt++; if (mon_vx[0] !== 3) $display("[TB] FAIL basic_vx: got %0d expected 3", mon_vx[0]); else pass_cnt++;
            total_cnt++; if (mon_cyc[0] !== exp_cyc[0]) $display("[TB] FAIL basic_latency: got cycle %0d expected %0d", mon_cyc[0], exp_cyc[0]); else pass_cnt++;
        end
        total_cnt++; if (seq_err !== 1'b0) $display("[TB] FAIL basic_err: got %0b expected 0", seq_err); else pass_cnt++;
        idle(3);
        total_cnt++; if (voice_out !== 19'sd2588) $display("[TB] FAIL basic_hold: got %0d expected 2588", voice_out); else pass_cnt++;
        total_cnt++; if (mon_val.size() !== 1) $display("[TB] FAIL basic_single_strobe: got %0d expected 1", mon_val.size()); else pass_cnt++;
    endtask

    task automatic test_level();
        clear_queues();
        voice_free = '0;
        osc_level  = 32'h0101_0101;
        send_group(1, -1, 0, 0, 0, 0, 0);
        idle(1);
        osc_level = 32'h8080_8080;
        send_group(1, 32767, 0, 0, 0, 0, 0);
        idle(1);
        send_group(2, 32767, 32767, 32767, 32767, 0, 0);
        idle(3);
        total_cnt++; if (mon_val.size() !== 3) $display("[TB] FAIL level_count: got %0d expected 3", mon_val.size()); else pass_cnt++;
        if (mon_val.size() >= 3) begin
            total_cnt++; if (mon_val[0] !== -1) $display("[TB] FAIL level_floor: got %0d expected -1", mon_val[0]); else pass_cnt++;
            total_cnt++; if (mon_val[1] !== 16383) $display("[TB] FAIL level_half: got %0d expected 16383", mon_val[1]); else pass_cnt++;
            total_cnt++; if (mon_val[2] !== 65532) $display("[TB] FAIL level_half4: got %0d expected 65532", mon_val[2]); else pass_cnt++;
        end
    endtask

    task automatic test_max();
        clear_queues();
        osc_level = 32'hFFFF_FFFF; voice_free = '0;
        send_group(4, 65535, 65535, 65535, 65535, 0, 0);
        send_group(5, -65536, -65536, -65536, -65536, 0, 0);
        idle(3);
        total_cnt++; if (mon_val.size() !== 2) $display("[TB] FAIL max_count: got %0d expected 2", mon_val.size()); else pass_cnt++;
        if (mon_val.size() >= 2) begin
            total_cnt++; if (mon_val[0] !== MAX_POS) $display("[TB] FAIL max_pos: got %0d expected %0d", mon_val[0], MAX_POS); else pass_cnt++;
            total_cnt++; if (mon_val[1] !== MAX_NEG) $display("[TB] FAIL max_neg: got %0d expected %0d", mon_val[1], MAX_NEG); else pass_cnt++;
        end
    endtask

    task automatic test_mute();
        clear_queues();
        osc_level = 32'hFFFF_FFFF; voice_free = 8'b0010_0000;
        send_group(5, 1000, 2000, 3000, 4000, 0, 0);
        send_group(6, 1000, 2000, -500, 100, 0, 0);
        idle(3);
        total_cnt++; if (mon_val.size() !== 2) $display("[TB] FAIL mute_count: got %0d expected 2", mon_val.size()); else pass_cnt++;
        if (mon_val.size() >= 2) begin
            total_cnt++; if (mon_val[0] !== 0 || mon_vx[0] !== 5) $display("[TB] FAIL mute_val: got %0d vx %0d expected 0 vx 5", mon_val[0], mon_vx[0]); else pass_cnt++;
            total_cnt++; if (mon_val[1] !== 2588 || mon_vx[1] !== 6) $display("[TB] FAIL mute_next: got %0d vx %0d expected 2588 vx 6", mon_val[1], mon_vx[1]); else pass_cnt++;
            total_cnt++; if (mon_cyc[1] !== exp_cyc[1] || mon_cyc[1] - mon_cyc[0] !== 4) $display("[TB] FAIL mute_no_bubble: got cycles %0d,%0d expected %0d,%0d", mon_cyc[0], mon_cyc[1], exp_cyc[0], exp_cyc[1]); else pass_cnt++;
        end
        voice_free = '0;
    endtask

    task automatic test_gap();
        clear_queues();
        osc_level = 32'hFFFF_FFFF;
        send_group(0, 1000, 2000, -500, 100, 5, 0);
        idle(3);
        total_cnt++; if (mon_val.size() !== 1) $display("[TB] FAIL gap_count: got %0d expected 1", mon_val.size()); else pass_cnt++;
        if (mon_val.size() >= 1) begin
            total_cnt++; if (mon_val[0] !== 2588 || mon_cyc[0] !== exp_cyc[0]) $display("[TB] FAIL gap_sum: got %0d at %0d expected 2588 at %0d", mon_val[0], mon_cyc[0], exp_cyc[0]); else pass_cnt++;
        end
    endtask

    task automatic test_order();
        clear_queues();
        osc_level = 32'hFFFF_FFFF; voice_free = '0;
        slot_sum = 0;
        send_slot(2, 0, 100, 0);
        send_slot(2, 1, 200, 0);
        send_slot(2, 3, 300, 0);
        idle(4);
        total_cnt++; if (seq_err !== 1'b1) $display("[TB] FAIL order_skip_err: got %0b expected 1", seq_err); else pass_cnt++;
        total_cnt++; if (mon_val.size() !== 0) $display("[TB] FAIL order_skip_nostrobe: got %0d expected 0", mon_val.size()); else pass_cnt++;
        send_group(2, 1000, 2000, -500, 100, 0, 0);
        idle(3);
        total_cnt++; if (mon_val.size() !== 1 || mon_val[0] !== 2588) $display("[TB] FAIL order_recover: got %0d strobes expected one of 2588", mon_val.size()); else pass_cnt++;
        total_cnt++; if (seq_err !== 1'b1) $display("[TB] FAIL order_sticky: got %0b expected 1", seq_err); else pass_cnt++;
        pulse_err_clr();
        total_cnt++; if (seq_err !== 1'b0) $display("[TB] FAIL order_clr: got %0b expected 0", seq_err); else pass_cnt++;
        send_slot(2, 2, 5, 0);
        @(posedge clk); #1; sine_valid = 1'b0; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        total_cnt++; if (seq_err !== 1'b1) $display("[TB] FAIL order_set_wins: got %0b expected 1", seq_err); else pass_cnt++;
        pulse_err_clr();
        clear_queues();
        send_slot(4, 0, 111, 0);
        send_slot(4, 1, 222, 0);
        send_group(7, 1000, 2000, -500, 100, 0, 0);
        idle(3);
        total_cnt++; if (seq_err !== 1'b1) $display("[TB] FAIL order_vx_err: got %0b expected 1", seq_err); else pass_cnt++;
        total_cnt++; if (mon_val.size() !== 1) $display("[TB] FAIL order_vx_count: got %0d expected 1", mon_val.size()); else pass_cnt++;
        if (mon_val.size() >= 1) begin
            total_cnt++; if (mon_val[0] !== 2588 || mon_vx[0] !== 7 || mon_cyc[0] !== exp_cyc[0]) $display("[TB] FAIL order_restart: got %0d vx %0d at %0d expected 2588 vx 7 at %0d", mon_val[0], mon_vx[0], mon_cyc[0], exp_cyc[0]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        osc_level = 32'hFFFF_FFFF;
        slot_sum = 0;
        send_slot(1, 0, 1000, 0);
        send_slot(1, 1, 2000, 0);
        @(posedge clk); #1; sine_valid = 1'b0; reset_reg = 1'b1;
        @(posedge clk); #1; reset_reg = 1'b0;
        total_cnt++; if (seq_err !== 1'b0) $display("[TB] FAIL rstmid_err0: got %0b expected 0", seq_err); else pass_cnt++;
        total_cnt++; if (voice_out !== 19'sd0) $display("[TB] FAIL rstmid_out: got %0d expected 0", voice_out); else pass_cnt++;
        send_slot(1, 2, -500, 0);
        send_slot(1, 3, 100, 0);
        idle(4);
        total_cnt++; if (mon_val.size() !== 0) $display("[TB] FAIL rstmid_nostrobe: got %0d expected 0", mon_val.size()); else pass_cnt++;
        total_cnt++; if (seq_err !== 1'b1) $display("[TB] FAIL rstmid_err1: got %0b expected 1", seq_err); else pass_cnt++;
    endtask

    task automatic test_random();
        int n;
        pulse_err_clr();
        clear_queues();
        for (int g = 0; g < 30; g++) begin
            send_group($urandom_range(0, 7),
                       $urandom_range(0, 131071) - 65536, $urandom_range(0, 131071) - 65536,
                       $urandom_range(0, 131071) - 65536, $urandom_range(0, 131071) - 65536,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1'b1);
        end
        idle(4);
        total_cnt++; if (mon_val.size() !== exp_val.size()) $display("[TB] FAIL rand_count: got %0d expected %0d", mon_val.size(), exp_val.size()); else pass_cnt++;
        n = (mon_val.size() < exp_val.size()) ? mon_val.size() : exp_val.size();
        for (int i = 0; i < n; i++) begin
            total_cnt++;
            if (mon_val[i] !== exp_val[i] || mon_vx[i] !== exp_vx[i] || mon_cyc[i] !== exp_cyc[i])
                $display("[TB] FAIL rand_group%0d: got %0d vx %0d at %0d expected %0d vx %0d at %0d",
                         i, mon_val[i], mon_vx[i], mon_cyc[i], exp_val[i], exp_vx[i], exp_cyc[i]);
            else pass_cnt++;
        end
        total_cnt++; if (seq_err !== 1'b0) $display("[TB] FAIL rand_err: got %0b expected 0", seq_err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level();
        test_max();
        test_mute();
        test_gap();
        test_order();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
